// File: rtl/dot_msg_dispatch_if.sv
// dot_msg_dispatch_if: message input and dot-controller output bundle.
//   slave  (dispatcher): takes msg/msg_ready; drives dm_* strobes, busy and counters.
//   master (producer/monitor): the mirror image.
interface dot_msg_dispatch_if;
    logic [31:0] msg;
    logic        msg_ready;
    logic        dm_write;
    logic        dm_enable;
    logic [4:0]  dm_col_addr;
    logic [6:0]  dm_row_in;
    logic        busy;
    logic [7:0]  err_count;
    logic [7:0]  drop_count;
    modport slave (
        input  msg, msg_ready,
        output dm_write, dm_enable, dm_col_addr, dm_row_in, busy, err_count, drop_count
    );
    modport master (
        output msg, msg_ready,
        input  dm_write, dm_enable, dm_col_addr, dm_row_in, busy, err_count, drop_count
    );
endinterface

// File: rtl/dot_msg_dispatch.sv
// dot_msg_dispatch: validates decoded messages and turns them into dot-matrix column writes.
//   clk, reset : clock and synchronous active-high reset
//   bus        : msg/msg_ready in; dm_write, dm_enable, dm_col_addr, dm_row_in,
//                busy, err_count, drop_count out
module dot_msg_dispatch #(
    parameter int NUM_COLS = 5
) (
    input logic           clk,
    input logic           reset,
    dot_msg_dispatch_if.slave bus
);
    typedef enum logic [2:0] {IDLE, CHECK, WRITE, FILL, DONE} state_t;
    state_t      state, nextState;
    logic [31:0] msgReg;
    logic [7:0]  opcode, column, rowData, checkByte;
    logic        checkOk, colOk, lastCol;
    logic        busy, accept, reject, setEnable, startWrite, startFill, stepFill, drop;
    logic        dmWrite, dmEnable;
    logic [4:0]  colAddr;
    logic [6:0]  rowIn;
    logic [7:0]  errCount, dropCount;

    assign {opcode, column, rowData, checkByte} = msgReg;
    assign checkOk = checkByte == (opcode ^ column ^ rowData);
    // full 8-bit compare so upper column bits still make the address illegal
    assign colOk   = column < 8'(NUM_COLS);
    // the column address register doubles as the fill counter
    assign lastCol = colAddr == 5'(NUM_COLS - 1);

    always_ff @(posedge clk)
        if (reset) state <= IDLE;
        else       state <= nextState;

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    nextState = bus.msg_ready ? CHECK : IDLE;
            CHECK:   nextState = !checkOk ? DONE :
                                 (opcode == 8'h01 && colOk) ? WRITE :
                                 (opcode == 8'h02 || opcode == 8'h03) ? FILL : DONE;
            WRITE:   nextState = DONE;
            FILL:    nextState = lastCol ? DONE : FILL;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        busy       = state != IDLE;
        accept     = state == IDLE && bus.msg_ready;
        drop       = busy && bus.msg_ready;
        startWrite = state == CHECK && nextState == WRITE;
        startFill  = state == CHECK && nextState == FILL;
        stepFill   = state == FILL && !lastCol;
        setEnable  = state == CHECK && checkOk && opcode == 8'h04;
        reject     = state == CHECK && !(startWrite || startFill || setEnable);
    end

    // strobe and address are registered one cycle ahead so they line up with WRITE/FILL
    always_ff @(posedge clk)
        if (reset) begin
            msgReg    <= '0;
            dmWrite   <= 1'b0;
            dmEnable  <= 1'b0;
            colAddr   <= '0;
            rowIn     <= '0;
            errCount  <= '0;
            dropCount <= '0;
        end else begin
            if (accept) msgReg <= bus.msg;
            dmWrite <= startWrite || startFill || stepFill;
            if (startWrite) begin
                colAddr <= column[4:0];
                rowIn   <= rowData[6:0];
            end else if (startFill) begin
                colAddr <= '0;
                rowIn   <= opcode == 8'h02 ? rowData[6:0] : '0;
            end else if (stepFill) colAddr <= colAddr + 5'd1;
            if (setEnable) dmEnable <= rowData[0];
            if (reject && errCount != 8'hFF) errCount <= errCount + 8'd1;
            if (drop && dropCount != 8'hFF) dropCount <= dropCount + 8'd1;
        end

    assign bus.dm_write    = dmWrite;
    assign bus.dm_enable   = dmEnable;
    assign bus.dm_col_addr = colAddr;
    assign bus.dm_row_in   = rowIn;
    assign bus.busy        = busy;
    assign bus.err_count   = errCount;
    assign bus.drop_count  = dropCount;
endmodule

// File: tb/tb_dot_msg_dispatch.sv
// tb_dot_msg_dispatch: directed vector table plus hand sequences for dot_msg_dispatch.
module tb_dot_msg_dispatch;
    typedef struct {
        logic [31:0] msg;
        int          writes;
        int          col0;
        int          row;
        int          err;
        int          en;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    vec_t vecs[12];

    dot_msg_dispatch_if bus();
    dot_msg_dispatch #(.NUM_COLS(5)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // pulse one message, follow it until IDLE, optionally inject a second pulse at cycle dropAt
    task automatic runMsg(input string tag, input vec_t v, input int dropAt);
        int nW = 0;
        int firstC = -1;
        int idleC = -1;
        @(posedge clk) #1;
        bus.msg = v.msg;
        bus.msg_ready = 1'b1;
        @(posedge clk) #1;
        bus.msg_ready = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (c == dropAt) bus.msg_ready = 1'b1;
            if (c == dropAt + 1) bus.msg_ready = 1'b0;
            if (bus.dm_write) begin
                if (firstC < 0) firstC = c;
                check({tag, " col"}, int'(bus.dm_col_addr), v.col0 + nW);
                check({tag, " row"}, int'(bus.dm_row_in), v.row);
                nW++;
            end
            if (!bus.busy) begin
                idleC = c;
                break;
            end
        end
        check({tag, " writes"}, nW, v.writes);
        check({tag, " first_write_cycle"}, firstC, v.writes > 0 ? 2 : -1);
        check({tag, " idle_cycle"}, idleC, v.writes > 0 ? v.writes + 3 : 3);
        check({tag, " err_count"}, int'(bus.err_count), v.err);
        check({tag, " dm_enable"}, int'(bus.dm_enable), v.en);
    endtask

    task automatic checkResetValues(input string tag);
        check({tag, " busy"}, int'(bus.busy), 0);
        check({tag, " dm_write"}, int'(bus.dm_write), 0);
        check({tag, " dm_enable"}, int'(bus.dm_enable), 0);
        check({tag, " dm_col_addr"}, int'(bus.dm_col_addr), 0);
        check({tag, " dm_row_in"}, int'(bus.dm_row_in), 0);
        check({tag, " err_count"}, int'(bus.err_count), 0);
        check({tag, " drop_count"}, int'(bus.drop_count), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nW;
        vec_t single;
        vecs[0]  = '{32'h01025556, 1, 2, 'h55, 0, 0};
        vecs[1]  = '{32'h01042A2F, 1, 4, 'h2A, 0, 0};
        vecs[2]  = '{32'h02007F7D, 5, 0, 'h7F, 0, 0};
        vecs[3]  = '{32'h03000003, 5, 0, 'h00, 0, 0};
        vecs[4]  = '{32'h0200FFFD, 5, 0, 'h7F, 0, 0};
        vecs[5]  = '{32'h01025500, 0, 0, 0, 1, 0};
        vecs[6]  = '{32'h01051115, 0, 0, 0, 2, 0};
        vecs[7]  = '{32'h09000009, 0, 0, 0, 3, 0};
        vecs[8]  = '{32'h01E111F1, 0, 0, 0, 4, 0};
        vecs[9]  = '{32'h04000105, 0, 0, 0, 4, 1};
        vecs[10] = '{32'h00000000, 0, 0, 0, 5, 1};
        vecs[11] = '{32'h04000004, 0, 0, 0, 5, 0};
        single   = '{32'h01025556, 1, 2, 'h55, 0, 0};
        bus.msg = '0;
        bus.msg_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkResetValues("reset");
        for (int i = 0; i < 12; i++)
            runMsg($sformatf("v%0d", i), vecs[i], 0);
        check("no_drop_yet", int'(bus.drop_count), 0);
        runMsg("drop_in_done", '{32'h01031113, 1, 3, 'h11, 5, 0}, 3);
        check("drop_in_done count", int'(bus.drop_count), 1);
        runMsg("drop_in_fill", '{32'h02005557, 5, 0, 'h55, 5, 0}, 4);
        check("drop_in_fill count", int'(bus.drop_count), 2);
        @(posedge clk) #1;
        bus.msg = 32'h01025556;
        bus.msg_ready = 1'b1;
        reset = 1'b1;
        @(posedge clk) #1;
        bus.msg_ready = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        checkResetValues("reset_prio");
        nW = 0;
        repeat (4) begin
            @(negedge clk);
            nW += int'(bus.dm_write);
        end
        check("reset_prio writes", nW, 0);
        @(posedge clk) #1;
        bus.msg = 32'h01025500;
        bus.msg_ready = 1'b1;
        repeat (1200) @(posedge clk);
        #1 bus.msg_ready = 1'b0;
        repeat (5) @(negedge clk);
        check("sat err_count", int'(bus.err_count), 255);
        check("sat drop_count", int'(bus.drop_count), 255);
        @(posedge clk) #1;
        bus.msg = 32'h02007F7D;
        bus.msg_ready = 1'b1;
        @(posedge clk) #1;
        bus.msg_ready = 1'b0;
        nW = 0;
        for (int c = 1; c <= 20 && nW < 3; c++) begin
            @(negedge clk);
            if (bus.dm_write) nW++;
        end
        check("abort third_write seen", nW, 3);
        check("abort third_write col", int'(bus.dm_col_addr), 2);
        reset = 1'b1;
        @(posedge clk) #1;
        reset = 1'b0;
        @(negedge clk);
        checkResetValues("abort");
        nW = 0;
        repeat (6) begin
            @(negedge clk);
            nW += int'(bus.dm_write);
        end
        check("abort further_writes", nW, 0);
        runMsg("after_abort", single, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
